// File: rtl/lcd_controller.sv
// lcd_controller: HD44780-style 4-bit LCD power-up/init sequencer and byte writer.
module lcd_controller #(
  parameter int POWERUP_CYCLES    = 750000,
  parameter int INIT_WAIT_CYCLES  = 205000,
  parameter int SETUP_CYCLES      = 2,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [3:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic       init_done
);
  localparam logic [23:0] PU = 24'(POWERUP_CYCLES);
  localparam logic [23:0] IW = 24'(INIT_WAIT_CYCLES);
  localparam logic [23:0] SU = 24'(SETUP_CYCLES);
  localparam logic [23:0] EP = 24'(E_PULSE_CYCLES);
  localparam logic [23:0] CW = 24'(CMD_WAIT_CYCLES);
  localparam logic [23:0] LW = 24'(CLEAR_WAIT_CYCLES);
  localparam logic [31:0] INIT_BYTES = 32'h28_0C_06_01;
  typedef enum logic [3:0] {
    PWRUP, INIT_NIB, INIT_WAIT, SETUP_HI, PULSE_HI, GAP, SETUP_LO, PULSE_LO, EXEC_WAIT, IDLE
  } state_t;
  state_t      state;
  logic [23:0] cnt;
  logic [2:0]  idx;
  logic        rs_q;
  logic [7:0]  byte_q;
  logic        last;
  logic [1:0]  k;
  logic [7:0]  next_byte;
  logic [23:0] exec_len;
  assign last      = cnt == 24'd1;
  // idx 0..3 walks the init nibbles, 4..7 the init bytes; k picks the next init byte
  assign k         = idx[1:0] + 2'd1;
  assign next_byte = INIT_BYTES[{~k, 3'b000} +: 8];
  assign exec_len  = (!rs_q && byte_q[7:2] == 6'd0 && byte_q[1:0] != 2'd0) ? LW : CW;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= PWRUP;
      cnt       <= PU;
      idx       <= 3'd0;
      rs_q      <= 1'b0;
      byte_q    <= 8'h00;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 4'h0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      cnt <= cnt - 24'd1;
      case (state)
        PWRUP: if (last) begin
          state    <= INIT_NIB;
          cnt      <= SU;
          lcd_data <= 4'h3;
        end
        INIT_NIB: if (last) begin
          state <= lcd_e ? INIT_WAIT : INIT_NIB;
          cnt   <= lcd_e ? IW : EP;
          lcd_e <= ~lcd_e;
        end
        INIT_WAIT: if (last) begin
          idx <= idx + 3'd1;
          cnt <= SU;
          if (idx == 3'd3) begin
            state    <= SETUP_HI;
            rs_q     <= 1'b0;
            byte_q   <= next_byte;
            lcd_data <= next_byte[7:4];
          end else begin
            state    <= INIT_NIB;
            lcd_data <= (idx == 3'd2) ? 4'h2 : 4'h3;
          end
        end
        SETUP_HI: if (last) begin
          state <= PULSE_HI;
          cnt   <= EP;
          lcd_e <= 1'b1;
        end
        PULSE_HI: if (last) begin
          state <= GAP;
          cnt   <= EP;
          lcd_e <= 1'b0;
        end
        GAP: if (last) begin
          state    <= SETUP_LO;
          cnt      <= SU;
          lcd_data <= byte_q[3:0];
        end
        SETUP_LO: if (last) begin
          state <= PULSE_LO;
          cnt   <= EP;
          lcd_e <= 1'b1;
        end
        PULSE_LO: if (last) begin
          state <= EXEC_WAIT;
          cnt   <= exec_len;
          lcd_e <= 1'b0;
        end
        EXEC_WAIT: if (last) begin
          if (!init_done && idx != 3'd7) begin
            state    <= SETUP_HI;
            cnt      <= SU;
            idx      <= idx + 3'd1;
            byte_q   <= next_byte;
            lcd_data <= next_byte[7:4];
          end else begin
            state     <= IDLE;
            wr_ready  <= 1'b1;
            init_done <= 1'b1;
            lcd_rs    <= 1'b0;
            lcd_data  <= 4'h0;
          end
        end
        IDLE: if (wr_valid && wr_ready) begin
          state    <= SETUP_HI;
          cnt      <= SU;
          wr_ready <= 1'b0;
          rs_q     <= wr_rs;
          byte_q   <= wr_data;
          lcd_rs   <= wr_rs;
          lcd_data <= wr_data[7:4];
        end
        default: state <= PWRUP;
      endcase
    end
  end
endmodule
